// File: rtl/icache_direct.sv
// ---------------------------------------------------------------------------
// icache_direct
//
// Direct-mapped, one-word-per-block instruction cache sitting between the
// datapath fetch port and memory control. Hits are answered combinationally
// in the same cycle. Misses issue a single-word read, install the returned
// word and then serve the fetch as a hit. Saturating hit/miss counters are
// kept for performance runs.
//
// Ports:
//   CLK         clock, all state updates on the rising edge
//   RST         synchronous active-high reset
//   imemREN     fetch request from the datapath
//   imemaddr    fetch byte address (bits [1:0] ignored)
//   flush       invalidate every line at the edge
//   ihit        fetch satisfied this cycle
//   imemload    instruction word, valid when ihit=1 (0 otherwise)
//   iREN        read request to memory control (high throughout FETCH)
//   iaddr       word-aligned miss address (0 outside FETCH)
//   iwait       memory control busy; 0 means iload is valid this cycle
//   iload       word returned by memory control
//   hit_count   number of ihit cycles, saturating
//   miss_count  number of misses issued, saturating
//   fsm_state   debug view of the FSM (0 = IDLE, 1 = FETCH)
//
// INDEX_W is expected to lie in 1..8.
// ---------------------------------------------------------------------------
module icache_direct #(
    parameter int INDEX_W = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        flush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic        fsm_state
);

    localparam int SETS  = 1 << INDEX_W;
    localparam int TAG_W = 30 - INDEX_W;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t              state;
    logic [SETS-1:0]     valid;
    logic [TAG_W-1:0]    tag_mem  [SETS];
    logic [31:0]         data_mem [SETS];
    logic [31:0]         miss_addr;
    logic [31:0]         hit_cnt;
    logic [31:0]         miss_cnt;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic [INDEX_W-1:0]  fill_idx;
    logic                hit;
    logic                fill_done;
    logic                unused_offset;

    // Byte offset within the word is irrelevant to a word cache.
    assign unused_offset = &{1'b0, imemaddr[1:0]};

    assign req_tag  = imemaddr[31:INDEX_W+2];
    assign req_idx  = imemaddr[INDEX_W+1:2];
    assign fill_tag = miss_addr[31:INDEX_W+2];
    assign fill_idx = miss_addr[INDEX_W+1:2];

    // A hit is only reported in IDLE, so the completion cycle of a fill
    // never doubles as a hit.
    assign hit = imemREN && valid[req_idx] && (tag_mem[req_idx] == req_tag)
                 && (state == IDLE);

    assign ihit     = hit;
    assign imemload = hit ? data_mem[req_idx] : 32'h0;

    // Memory handshake: iREN is held high for every FETCH cycle and the
    // address is held stable; the read is complete in the first cycle
    // where iwait is low, and iload is consumed at that edge. There is no
    // abort path other than reset.
    assign iREN      = (state == FETCH);
    assign iaddr     = (state == FETCH) ? miss_addr : 32'h0;
    assign fsm_state = state;

    assign fill_done = (state == FETCH) && !iwait;

    assign hit_count  = hit_cnt;
    assign miss_count = miss_cnt;

    // Control state: FSM, valid bits, miss address and counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            valid     <= '0;
            miss_addr <= 32'h0;
            hit_cnt   <= 32'h0;
            miss_cnt  <= 32'h0;
        end else begin
            if (hit && (hit_cnt != 32'hFFFF_FFFF)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end

            case (state)
                IDLE: begin
                    if (imemREN && !hit && !flush) begin
                        miss_addr <= {imemaddr[31:2], 2'b00};
                        if (miss_cnt != 32'hFFFF_FFFF) begin
                            miss_cnt <= miss_cnt + 32'd1;
                        end
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        // A flush landing on the completion edge wins:
                        // the returned word is dropped.
                        if (!flush) begin
                            valid[fill_idx] <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed last so it overrides any install on the same edge.
            if (flush) begin
                valid <= '0;
            end
        end
    end

    // Tag/data arrays carry no reset; a stale entry is harmless while its
    // valid bit is clear, so they may be written even on a flushed fill.
    always_ff @(posedge CLK) begin
        if (!RST && fill_done) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// ---------------------------------------------------------------------------
// tb_icache_direct
//
// Bench for icache_direct (INDEX_W = 4). Inputs are driven 1 time unit after
// the rising edge; outputs are sampled on the falling edge. A small memory
// responder answers reads after a configurable number of iwait cycles.
// Expected fetch data is pushed to exp_q when a fetch is driven and popped
// when the cache reports a hit.
// ---------------------------------------------------------------------------
module tb_icache_direct;

  localparam int INDEX_W = 4;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic        fsm_state;

  always #5 CLK = ~CLK;

  icache_direct #(.INDEX_W(INDEX_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .flush      (flush),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .fsm_state  (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          wait_cfg = 0;
  int          busy_cnt = 0;
  int          fetch_hit_viol = 0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2001_0005;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    iwait = 1'b1;
    iload = 32'h0;
    forever begin
      @(negedge CLK);
      if (iREN === 1'b1) begin
        if (busy_cnt < wait_cfg) begin
          iwait = 1'b1;
          busy_cnt++;
        end else begin
          iwait = 1'b0;
          iload = mem_model(iaddr);
          busy_cnt = 0;
        end
      end else begin
        iwait = 1'b1;
        iload = 32'hDEAD_BEEF;
        busy_cnt = 0;
      end
    end
  end

  // ihit must never coincide with an outstanding read.
  initial begin
    forever begin
      @(negedge CLK);
      if (iREN === 1'b1 && ihit === 1'b1) fetch_hit_viol++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_fetch(input logic [31:0] addr, input int wcycles);
    @(posedge CLK); #1;
    wait_cfg = wcycles;
    imemREN  = 1'b1;
    imemaddr = addr;
    exp_q.push_back(mem_model({addr[31:2], 2'b00}));
  endtask

  task automatic sb_sample(input string tag);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check_eq({tag, "_hit"}, {31'd0, ihit}, 32'd1);
      check_eq({tag, "_data"}, imemload, exp);
    end
  endtask

  // Waits for the hit, counting iREN cycles on the way; returns on the
  // falling edge of the hit cycle.
  task automatic wait_hit(input string tag, input int exp_ren);
    int ren;
    bit got;
    ren = 0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      if (ihit === 1'b1) begin
        got = 1'b1;
        sb_sample(tag);
      end else if (iREN === 1'b1) begin
        ren++;
      end
    end
    if (!got) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      check_eq({tag, "_ren_cycles"}, ren, exp_ren);
    end
  endtask

  task automatic idle_and_check_counts(input string tag, input logic [31:0] hits,
                                       input logic [31:0] misses);
    @(posedge CLK); #1;
    imemREN = 1'b0;
    @(negedge CLK);
    check_eq({tag, "_hit_count"}, hit_count, hits);
    check_eq({tag, "_miss_count"}, miss_count, misses);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    RST      = 1'b1;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    flush    = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Reset state and first miss at address 0 with an immediate return.
    RST      = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h0;
    wait_cfg = 0;
    exp_q.push_back(mem_model(32'h0));
    @(negedge CLK);
    check_eq("rst_ihit", {31'd0, ihit}, 32'd0);
    check_eq("rst_imemload", imemload, 32'h0);
    check_eq("rst_iREN", {31'd0, iREN}, 32'd0);
    check_eq("rst_iaddr", iaddr, 32'h0);
    check_eq("rst_hit_count", hit_count, 32'd0);
    check_eq("rst_miss_count", miss_count, 32'd0);
    @(negedge CLK);
    check_eq("a_iREN", {31'd0, iREN}, 32'd1);
    check_eq("a_iaddr", iaddr, 32'h0);
    check_eq("a_state", {31'd0, fsm_state}, 32'd1);
    check_eq("a_miss_count", miss_count, 32'd1);
    check_eq("a_ihit_in_fetch", {31'd0, ihit}, 32'd0);
    @(negedge CLK);
    sb_sample("a_fill");

    // Cold miss with 3 wait cycles, then hold the address for 3 more hits.
    drive_fetch(32'h0000_0040, 3);
    wait_hit("b_cold", 4);
    repeat (3) begin
      exp_q.push_back(32'h2001_0005);
      @(negedge CLK);
      sb_sample("b_hold");
    end
    idle_and_check_counts("b", 32'd5, 32'd2);

    // Byte offset ignored.
    drive_fetch(32'h0000_0043, 0);
    wait_hit("c_offset", 0);

    // Conflict eviction on index 0.
    drive_fetch(32'h0000_0080, 1);
    wait_hit("d_evict", 2);
    drive_fetch(32'h0000_0040, 0);
    wait_hit("d_refetch", 1);
    idle_and_check_counts("d", 32'd8, 32'd4);

    // Flush in IDLE with three lines resident.
    drive_fetch(32'h0000_0044, 0);
    wait_hit("e_fill1", 1);
    drive_fetch(32'h0000_0048, 0);
    wait_hit("e_fill2", 1);
    @(posedge CLK); #1;
    imemREN = 1'b0;
    flush   = 1'b1;
    @(posedge CLK); #1;
    flush   = 1'b0;
    drive_fetch(32'h0000_0040, 0);
    wait_hit("e_after_flush_40", 1);
    drive_fetch(32'h0000_0044, 0);
    wait_hit("e_after_flush_44", 1);
    drive_fetch(32'h0000_0048, 0);
    wait_hit("e_after_flush_48", 1);

    // Flush on the fill completion edge: the line must not be installed.
    @(posedge CLK); #1;
    wait_cfg = 2;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0050;
    repeat (3) @(negedge CLK);
    @(posedge CLK); #1;
    flush = 1'b1;
    @(negedge CLK);
    check_eq("f_completion_iREN", {31'd0, iREN}, 32'd1);
    @(posedge CLK); #1;
    flush = 1'b0;
    exp_q.push_back(mem_model(32'h0000_0050));
    wait_hit("f_flush_refill", 3);
    idle_and_check_counts("f", 32'd14, 32'd11);

    // Reset while the read is still busy.
    @(posedge CLK); #1;
    wait_cfg = 100;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0060;
    @(negedge CLK);
    @(negedge CLK);
    check_eq("g_busy_iREN", {31'd0, iREN}, 32'd1);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST      = 1'b0;
    imemREN  = 1'b0;
    wait_cfg = 0;
    @(negedge CLK);
    check_eq("g_iREN", {31'd0, iREN}, 32'd0);
    check_eq("g_iaddr", iaddr, 32'h0);
    check_eq("g_state", {31'd0, fsm_state}, 32'd0);
    check_eq("g_hit_count", hit_count, 32'd0);
    check_eq("g_miss_count", miss_count, 32'd0);
    drive_fetch(32'h0000_0060, 0);
    wait_hit("g_after_rst", 1);

    // Hit counter saturation.
    #1;
    force dut.hit_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.hit_cnt;
    repeat (3) begin
      exp_q.push_back(mem_model(32'h0000_0060));
      @(negedge CLK);
      sb_sample("h_sat");
      check_eq("h_sat_hit_count", hit_count, 32'hFFFF_FFFF);
    end
    check_eq("h_miss_count", miss_count, 32'd1);

    check_eq("no_hit_in_fetch", fetch_hit_viol, 32'd0);
    check_eq("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
